// File: rtl/aer_pkg.sv
// Shared types and helpers for the AER spike encoder.
// Optional feature macro used by the encoder: AER_ENCODER_SHADOW_EN.
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EOF  = 2'd2
    } aer_state_t;

    // The EOF/idle flag sits in the MSB of the bus word, just above the address.
    function automatic int unsigned flag_pos(input int unsigned addr_w);
        return addr_w;
    endfunction

    // Idle/EOF word: flag set and an all-ones address that decodes to no synapse.
    function automatic logic [31:0] idle_word(input int unsigned addr_w);
        return (32'(1) << (flag_pos(addr_w) + 1)) - 32'(1);
    endfunction

endpackage

// File: rtl/aer_spike_encoder_if.sv
// Spike-vector input handshake plus AER output bus of the spike encoder.
interface aer_spike_encoder_if #(
    parameter int unsigned NUM_IN = 5
);
    localparam int unsigned ADDR_W = $clog2(NUM_IN);
    localparam int unsigned CNT_W  = $clog2(NUM_IN + 1);
    localparam int unsigned BUS_W  = ADDR_W + 1;

    logic [NUM_IN-1:0] spike_vec;
    logic              spike_valid;
    logic              spike_ready;
    logic [BUS_W-1:0]  aer_bus;
    logic              frame_done;
    logic [CNT_W-1:0]  spike_count;

    // Encoder side: consumes spike vectors, drives the AER bus.
    modport master (
        input  spike_vec,
        input  spike_valid,
        output spike_ready,
        output aer_bus,
        output frame_done,
        output spike_count
    );

    // Neuron layer / synapse side.
    modport slave (
        output spike_vec,
        output spike_valid,
        input  spike_ready,
        input  aer_bus,
        input  frame_done,
        input  spike_count
    );

endinterface

// File: rtl/lsb_first_enc.sv
// Combinational find-first-set: index of the lowest set bit, 'none' when the vector is empty.
module lsb_first_enc #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0]                            vec,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]    idx,
    output logic                                    none
);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/aer_spike_encoder.sv
// Serialises one spike vector per timestep onto the AER bus: one address per
// clock in ascending order, then one EOF word carrying frame_done/spike_count.
// Optional macro AER_ENCODER_SHADOW_EN adds a one-deep shadow vector so the
// next frame can follow the EOF word without an IDLE cycle.
module aer_spike_encoder #(
    parameter int unsigned NUM_IN = 5
) (
    input  logic               clk,
    input  logic               reset,
    aer_spike_encoder_if.master bus
);
    import aer_pkg::*;

    localparam int unsigned ADDR_W = $clog2(NUM_IN);
    localparam int unsigned CNT_W  = $clog2(NUM_IN + 1);
    localparam int unsigned BUS_W  = ADDR_W + 1;
    localparam logic [BUS_W-1:0] IDLE_WORD = BUS_W'(idle_word(ADDR_W));

    aer_state_t        state;
    logic [NUM_IN-1:0] pending;
    logic [CNT_W-1:0]  run_count;
    logic [ADDR_W-1:0] enc_idx;
    logic              enc_none;
    logic              accept;
    logic              last_spike;
    logic [NUM_IN-1:0] clear_mask;

`ifdef AER_ENCODER_SHADOW_EN
    logic [NUM_IN-1:0] shadow;
    logic              shadow_full;
`endif

    lsb_first_enc #(.N(NUM_IN)) u_ffs (
        .vec  (pending),
        .idx  (enc_idx),
        .none (enc_none)
    );

    assign accept     = bus.spike_valid && bus.spike_ready;
    assign last_spike = ((pending & (pending - NUM_IN'(1))) == '0);
    assign clear_mask = ~(NUM_IN'(1) << enc_idx);

    // Frame FSM with registered bus, handshake and frame statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pending         <= '0;
            run_count       <= '0;
            bus.aer_bus     <= IDLE_WORD;
            bus.frame_done  <= 1'b0;
            bus.spike_count <= '0;
            bus.spike_ready <= 1'b1;
`ifdef AER_ENCODER_SHADOW_EN
            shadow          <= '0;
            shadow_full     <= 1'b0;
`endif
        end else begin
            bus.aer_bus    <= IDLE_WORD;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
`ifdef AER_ENCODER_SHADOW_EN
                    // A vector parked during the last EOF takes priority.
                    if (shadow_full) begin
                        pending         <= shadow;
                        state           <= (shadow != '0) ? SCAN : EOF;
                        shadow_full     <= 1'b0;
                        bus.spike_ready <= 1'b1;
                    end else if (accept) begin
                        pending <= bus.spike_vec;
                        state   <= (bus.spike_vec != '0) ? SCAN : EOF;
                    end
`else
                    if (accept) begin
                        pending         <= bus.spike_vec;
                        state           <= (bus.spike_vec != '0) ? SCAN : EOF;
                        bus.spike_ready <= 1'b0;
                    end
`endif
                end
                SCAN: begin
                    if (!enc_none) begin
                        bus.aer_bus <= {1'b0, enc_idx};
                        pending     <= pending & clear_mask;
                        run_count   <= run_count + CNT_W'(1);
                        if (last_spike) begin
                            state <= EOF;
                        end
                    end else begin
                        state <= EOF;
                    end
`ifdef AER_ENCODER_SHADOW_EN
                    if (accept) begin
                        shadow          <= bus.spike_vec;
                        shadow_full     <= 1'b1;
                        bus.spike_ready <= 1'b0;
                    end
`endif
                end
                EOF: begin
                    bus.frame_done  <= 1'b1;
                    bus.spike_count <= run_count;
                    run_count       <= '0;
`ifdef AER_ENCODER_SHADOW_EN
                    if (shadow_full) begin
                        pending         <= shadow;
                        state           <= (shadow != '0) ? SCAN : EOF;
                        shadow_full     <= 1'b0;
                        bus.spike_ready <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                    // Ready implies the shadow was empty, so this never collides with the unload.
                    if (accept) begin
                        shadow          <= bus.spike_vec;
                        shadow_full     <= 1'b1;
                        bus.spike_ready <= 1'b0;
                    end
`else
                    state           <= IDLE;
                    bus.spike_ready <= 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
